// File: rtl/i2s_sdi_tx.sv
`timescale 1ns/1ps
// I2S slave transmitter: shifts queued stereo PCM pairs out on sdi, MSB first, timed by
// the master's sck/ws, with a small valid/ready pair FIFO in front of the shifter.
module i2s_sdi_tx #(
    parameter int DW      = 24,
    parameter int SLOT_W  = 32,
    parameter int FIFO_AW = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             sck,
    input  logic             ws,
    output logic             sdi,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_left,
    input  logic [DW-1:0]    s_right,
    output logic [FIFO_AW:0] level,
    output logic             underrun
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(SLOT_W + 1);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_e;

    // Push port: a pair is taken on every CLK edge where s_valid && s_ready are both high;
    // s_ready comes from registered occupancy only and never looks at s_valid.
    state_e              state_q, state_d;
    logic                sck_m_q, sck_m_d, sck_s_q, sck_s_d, sck_p_q, sck_p_d;
    logic                ws_m_q, ws_m_d, ws_s_q, ws_s_d;
    logic                wsl_q, wsl_d, start_q, start_d;
    logic [SLOT_W-1:0]   shreg_q, shreg_d;
    logic [DW-1:0]       r_hold_q, r_hold_d;
    logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                underrun_q, underrun_d;
    logic [DW-1:0]       mem_l_q [DEPTH], mem_l_d [DEPTH];
    logic [DW-1:0]       mem_r_q [DEPTH], mem_r_d [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]    count_q, count_d;
    logic                s_ready_q, s_ready_d;
    logic                sck_rise, sck_fall, load, fifo_empty, push, pop;

    always_comb begin
        sck_m_d  = sck;
        sck_s_d  = sck_m_q;
        sck_p_d  = sck_s_q;
        ws_m_d   = ws;
        ws_s_d   = ws_m_q;
        sck_rise = sck_s_q & ~sck_p_q;
        sck_fall = ~sck_s_q & sck_p_q;

        // ws is sampled on sck rise; a change arms the slot load for the next sck fall,
        // which gives the one-bit I2S delay between the ws edge and the MSB.
        wsl_d   = wsl_q;
        start_d = start_q;
        if (sck_rise) begin
            wsl_d = ws_s_q;
            if (ws_s_q != wsl_q) start_d = 1'b1;
        end
        load       = sck_fall & start_q;
        fifo_empty = (count_q == '0);
        push       = s_valid & s_ready_q;
        pop        = load & ~wsl_q & en & ~fifo_empty;

        state_d    = state_q;
        shreg_d    = shreg_q;
        r_hold_d   = r_hold_q;
        bit_cnt_d  = bit_cnt_q;
        underrun_d = 1'b0;
        if (load) begin
            start_d   = 1'b0;
            bit_cnt_d = '0;
            if (!wsl_q) begin
                state_d = LEFT;
                if (!fifo_empty) begin
                    shreg_d  = SLOT_W'(mem_l_q[rd_ptr_q]) << (SLOT_W - DW);
                    r_hold_d = mem_r_q[rd_ptr_q];
                end else begin
                    shreg_d    = '0;
                    r_hold_d   = '0;
                    underrun_d = en;
                end
            end else if (state_q != IDLE) begin
                state_d = RIGHT;
                shreg_d = SLOT_W'(r_hold_q) << (SLOT_W - DW);
            end
        end else if (sck_fall) begin
            if (bit_cnt_q < CW'(SLOT_W)) bit_cnt_d = bit_cnt_q + 1'b1;
            shreg_d = (bit_cnt_q < CW'(SLOT_W - 1)) ? (shreg_q << 1) : '0;
        end
        if (!en) begin
            state_d = IDLE;
            shreg_d = '0;
        end

        mem_l_d  = mem_l_q;
        mem_r_d  = mem_r_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_l_d[wr_ptr_q] = s_left;
            mem_r_d[wr_ptr_q] = s_right;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        s_ready_d = (count_d != (FIFO_AW + 1)'(DEPTH));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            sck_m_q    <= 1'b0;
            sck_s_q    <= 1'b0;
            sck_p_q    <= 1'b0;
            ws_m_q     <= 1'b0;
            ws_s_q     <= 1'b0;
            wsl_q      <= 1'b0;
            start_q    <= 1'b0;
            shreg_q    <= '0;
            r_hold_q   <= '0;
            bit_cnt_q  <= '0;
            underrun_q <= 1'b0;
            mem_l_q    <= '{default: '0};
            mem_r_q    <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            s_ready_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            sck_m_q    <= sck_m_d;
            sck_s_q    <= sck_s_d;
            sck_p_q    <= sck_p_d;
            ws_m_q     <= ws_m_d;
            ws_s_q     <= ws_s_d;
            wsl_q      <= wsl_d;
            start_q    <= start_d;
            shreg_q    <= shreg_d;
            r_hold_q   <= r_hold_d;
            bit_cnt_q  <= bit_cnt_d;
            underrun_q <= underrun_d;
            mem_l_q    <= mem_l_d;
            mem_r_q    <= mem_r_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            s_ready_q  <= s_ready_d;
        end
    end

    assign sdi      = shreg_q[SLOT_W-1];
    assign s_ready  = s_ready_q;
    assign level    = count_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_sdi_tx.sv
`timescale 1ns/1ps
// Bench for i2s_sdi_tx: acts as the I2S master (sck period 80 ns, 32-bit slots), decodes
// sdi into left/right words and checks them, FIFO level and underrun against tables.
module tb_i2s_sdi_tx;
    logic        CLK, RST, en, sck, ws, sdi, s_valid, s_ready, underrun;
    logic [23:0] s_left, s_right;
    logic [2:0]  level;

    i2s_sdi_tx dut (
        .CLK(CLK), .RST(RST), .en(en), .sck(sck), .ws(ws), .sdi(sdi),
        .s_valid(s_valid), .s_ready(s_ready), .s_left(s_left), .s_right(s_right),
        .level(level), .underrun(underrun)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [23:0] l, r;
        logic [2:0]  exp_lvl;
        logic        exp_rdy;
    } push_t;

    // ev: 0 none, 1 push during the left pop, 2 drop en, 3 raise en, 4 pulse RST
    typedef struct {
        logic        pre_push;
        logic [23:0] pl, pr;
        int          ev_i, ev;
        logic        chk_l, chk_r;
        logic [31:0] exp_l, exp_r;
        logic [2:0]  exp_lvl;
    } frm_t;

    push_t       ptab [5];
    frm_t        ftab [12];
    int          n_vec = 0, n_err = 0;
    int          u_pulses = 0, u_high = 0;
    logic        prev_u = 1'b0;
    logic        prev_ws;
    logic [31:0] left_acc, right_acc, left_done, right_done;

    always @(negedge CLK) begin
        if (underrun) u_high++;
        if (underrun && !prev_u) u_pulses++;
        prev_u = underrun;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
        @(negedge CLK);
        s_valid = 1'b1;
        s_left  = l;
        s_right = r;
        @(negedge CLK);
        s_valid = 1'b0;
    endtask

    // Bit sampled on an sck rise belongs to the slot selected during the previous period.
    task automatic sample(input logic ws_v);
        if (!prev_ws) left_acc = {left_acc[30:0], sdi};
        else right_acc = {right_acc[30:0], sdi};
        if (!prev_ws && ws_v) left_done = left_acc;
        if (prev_ws && !ws_v) right_done = right_acc;
        prev_ws = ws_v;
    endtask

    task automatic period(input logic ws_v, input int ev, input logic [23:0] pl,
                          input logic [23:0] pr);
        sck = 1'b0;
        ws  = ws_v;
        case (ev)
            1: begin
                #16; s_left = pl; s_right = pr; s_valid = 1'b1;
                #10; s_valid = 1'b0;
                #14;
            end
            2: begin
                #30; check("sdi_before_en_off", {31'd0, sdi}, 32'd1);
                en = 1'b0;
                #8;  check("sdi_after_en_off", {31'd0, sdi}, 32'd0);
                #2;
            end
            3: begin
                #30; en = 1'b1;
                #10;
            end
            4: begin
                #30; check("sdi_before_rst", {31'd0, sdi}, 32'd1);
                RST = 1'b1;
                #1;
                check("rst_sdi", {31'd0, sdi}, 32'd0);
                check("rst_level", {29'd0, level}, 32'd0);
                check("rst_ready", {31'd0, s_ready}, 32'd1);
                check("rst_underrun", {31'd0, underrun}, 32'd0);
                #5; RST = 1'b0;
                #4;
            end
            default: #40;
        endcase
        sck = 1'b1;
        sample(ws_v);
        #40;
    endtask

    // Periods 1..31 left (ws=0), 32..63 right, 64 opens the next left slot.
    task automatic frame(input int k);
        @(posedge CLK); #7;
        for (int i = 1; i <= 64; i++)
            period((i >= 32 && i < 64), (i == ftab[k].ev_i) ? ftab[k].ev : 0,
                   ftab[k].pl, ftab[k].pr);
        if (ftab[k].chk_l) check($sformatf("frame%0d_left", k), left_done, ftab[k].exp_l);
        if (ftab[k].chk_r) check($sformatf("frame%0d_right", k), right_done, ftab[k].exp_r);
        @(negedge CLK);
        check($sformatf("frame%0d_level", k), {29'd0, level}, {29'd0, ftab[k].exp_lvl});
        check($sformatf("frame%0d_ready", k), {31'd0, s_ready},
              {31'd0, (ftab[k].exp_lvl != 3'd4)});
    endtask

    initial begin
        CLK = 1'b0; RST = 1'b1; en = 1'b0; sck = 1'b1; ws = 1'b1;
        s_valid = 1'b0; s_left = '0; s_right = '0;
        prev_ws = 1'b1; left_acc = '0; right_acc = '0; left_done = '0; right_done = '0;

        ptab[0] = '{24'hA5A5A5, 24'h5A5A5A, 3'd1, 1'b1};
        ptab[1] = '{24'h123456, 24'h654321, 3'd2, 1'b1};
        ptab[2] = '{24'hABCDEF, 24'hFEDCBA, 3'd3, 1'b1};
        ptab[3] = '{24'h800001, 24'h7FFFFE, 3'd4, 1'b0};
        ptab[4] = '{24'hDEAD00, 24'hBEEF00, 3'd4, 1'b0};

        ftab[0]  = '{1'b0, 24'h0, 24'h0, 0, 0, 1'b1, 1'b1, 32'hA5A5A500, 32'h5A5A5A00, 3'd3};
        ftab[1]  = '{1'b0, 24'h0, 24'h0, 0, 0, 1'b1, 1'b1, 32'h12345600, 32'h65432100, 3'd2};
        ftab[2]  = '{1'b0, 24'hC0FFEE, 24'h0BADF0, 1, 1, 1'b1, 1'b1,
                     32'hABCDEF00, 32'hFEDCBA00, 3'd2};
        ftab[3]  = '{1'b0, 24'h0, 24'h0, 0, 0, 1'b1, 1'b1, 32'h80000100, 32'h7FFFFE00, 3'd1};
        ftab[4]  = '{1'b0, 24'h0, 24'h0, 0, 0, 1'b1, 1'b1, 32'hC0FFEE00, 32'h0BADF000, 3'd0};
        ftab[5]  = '{1'b0, 24'h0, 24'h0, 0, 0, 1'b1, 1'b1, 32'h0, 32'h0, 3'd0};
        ftab[6]  = '{1'b0, 24'h0, 24'h0, 0, 0, 1'b1, 1'b1, 32'h0, 32'h0, 3'd0};
        ftab[7]  = '{1'b1, 24'h800000, 24'hFFFFFF, 40, 2, 1'b1, 1'b0, 32'h80000000, 32'h0, 3'd0};
        ftab[8]  = '{1'b1, 24'h3C3C3C, 24'hC3C3C3, 40, 3, 1'b1, 1'b1, 32'h0, 32'h0, 3'd1};
        ftab[9]  = '{1'b0, 24'h0, 24'h0, 0, 0, 1'b1, 1'b1, 32'h3C3C3C00, 32'hC3C3C300, 3'd0};
        ftab[10] = '{1'b1, 24'hFFFFFF, 24'h123456, 10, 4, 1'b0, 1'b1, 32'h0, 32'h0, 3'd0};
        ftab[11] = '{1'b0, 24'h0, 24'h0, 0, 0, 1'b1, 1'b1, 32'h0, 32'h0, 3'd0};

        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("reset_sdi", {31'd0, sdi}, 32'd0);
        check("reset_level", {29'd0, level}, 32'd0);
        check("reset_ready", {31'd0, s_ready}, 32'd1);
        check("reset_underrun", {31'd0, underrun}, 32'd0);

        // Fill with en low: FIFO must accept four pairs and refuse the fifth.
        for (int k = 0; k < 5; k++) begin
            push_pair(ptab[k].l, ptab[k].r);
            check($sformatf("push%0d_level", k), {29'd0, level}, {29'd0, ptab[k].exp_lvl});
            check($sformatf("push%0d_ready", k), {31'd0, s_ready}, {31'd0, ptab[k].exp_rdy});
        end

        en = 1'b1;
        @(posedge CLK); #7;
        period(1'b1, 0, 24'h0, 24'h0);
        period(1'b1, 0, 24'h0, 24'h0);
        period(1'b0, 0, 24'h0, 24'h0);
        check("preamble_level", {29'd0, level}, 32'd4);

        for (int k = 0; k < 12; k++) begin
            if (ftab[k].pre_push) push_pair(ftab[k].pl, ftab[k].pr);
            frame(k);
        end

        check("underrun_pulses", u_pulses, 32'd3);
        check("underrun_high_cycles", u_high, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
